// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: opcode and FSM state enums,
// plus the fixed prefixes used by the compare opcodes.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_SUB = 3'b000,
        OP_ADD = 3'b001,
        OP_OR  = 3'b010,
        OP_AND = 3'b011,
        OP_ASR = 3'b100,
        OP_ROL = 3'b101,
        OP_LT  = 3'b110,
        OP_EQ  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [2:0] LT_PREFIX = 3'b101;
    localparam logic [2:0] EQ_PREFIX = 3'b111;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational 4-bit ALU, modulo 16, no carry or flags.
module alu4_core
    import alu_seq_pkg::*;
(
    input  logic [3:0] rs,
    input  logic [3:0] rt,
    input  op_e        op,
    output logic [3:0] rd
);

    always_comb begin
        rd = 4'd0;
        case (op)
            OP_SUB:  rd = rs - rt;
            OP_ADD:  rd = rs + rt;
            OP_OR:   rd = rs | rt;
            OP_AND:  rd = rs & rt;
            OP_ASR:  rd = {rt[3], rt[3:1]};
            OP_ROL:  rd = {rs[2:0], rs[3]};
            OP_LT:   rd = {LT_PREFIX, (rs < rt)};
            OP_EQ:   rd = {EQ_PREFIX, (rs == rt)};
            default: rd = 4'd0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Four-state command sequencer (IDLE->READ->EXEC->DONE) around a small register file and alu4_core.
// Optional build macro ALU_SEQ_BYPASS_EN: load-immediate commands complete on the acceptance edge.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREG = 4,
    parameter int RA_W = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_ld,
    input  logic [2:0]      cmd_op,
    input  logic [RA_W-1:0] cmd_rs,
    input  logic [RA_W-1:0] cmd_rt,
    input  logic [RA_W-1:0] cmd_rd,
    input  logic [3:0]      cmd_imm,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [3:0]      res_data,
    output logic [RA_W-1:0] res_rd,
    output logic            busy
);

    state_e          state_reg, state_next;
    logic            ld_reg;
    op_e             op_reg;
    logic [RA_W-1:0] rs_reg, rt_reg, rd_reg;
    logic [3:0]      imm_reg;
    logic [3:0]      opa_reg, opb_reg, result_reg;
    logic [3:0]      regfile_reg [NREG];
    logic [3:0]      alu_out, wb_data;
    logic [RA_W-1:0] wb_rd;
    logic            accept, wb_en, bypass_ld;

    assign accept = cmd_valid && (state_reg == S_IDLE);

`ifdef ALU_SEQ_BYPASS_EN
    assign bypass_ld = accept && cmd_ld;
`else
    assign bypass_ld = 1'b0;
`endif

    // A bypassed load writes straight from the command fields; everything else from the latched command.
    assign wb_en   = (state_reg == S_EXEC) || bypass_ld;
    assign wb_rd   = bypass_ld ? cmd_rd : rd_reg;
    assign wb_data = bypass_ld ? cmd_imm : (ld_reg ? imm_reg : alu_out);

    alu4_core u_alu (
        .rs (opa_reg),
        .rt (opb_reg),
        .op (op_reg),
        .rd (alu_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_next = bypass_ld ? S_DONE : S_READ;
            end
            S_READ: state_next = S_EXEC;
            S_EXEC: state_next = S_DONE;
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_reg     <= 1'b0;
            op_reg     <= OP_SUB;
            rs_reg     <= '0;
            rt_reg     <= '0;
            rd_reg     <= '0;
            imm_reg    <= 4'd0;
            opa_reg    <= 4'd0;
            opb_reg    <= 4'd0;
            result_reg <= 4'd0;
        end else begin
            if (accept) begin
                ld_reg  <= cmd_ld;
                op_reg  <= op_e'(cmd_op);
                rs_reg  <= cmd_rs;
                rt_reg  <= cmd_rt;
                rd_reg  <= cmd_rd;
                imm_reg <= cmd_imm;
            end
            if (state_reg == S_READ) begin
                opa_reg <= regfile_reg[rs_reg];
                opb_reg <= regfile_reg[rt_reg];
            end
            if (wb_en) result_reg <= wb_data;
        end
    end

    // Kept in flops rather than RAM: reset must clear every entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regfile_reg[i] <= 4'd0;
        end else if (wb_en) begin
            regfile_reg[wb_rd] <= wb_data;
        end
    end

    assign res_data = result_reg;
    assign res_rd   = rd_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed and random commands against an arithmetic reference model.
module tb_alu_sequencer;

    localparam int NREG = 4;
    localparam int RA_W = 2;
`ifdef ALU_SEQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_ld = 1'b0;
    logic [2:0]      cmd_op = 3'd0;
    logic [RA_W-1:0] cmd_rs = '0, cmd_rt = '0, cmd_rd = '0;
    logic [3:0]      cmd_imm = 4'd0;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [3:0]      res_data;
    logic [RA_W-1:0] res_rd;
    logic            busy;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int accept_cycle = 0;
    int model [NREG];

    alu_sequencer #(.NREG(NREG), .RA_W(RA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ld    (cmd_ld),
        .cmd_op    (cmd_op),
        .cmd_rs    (cmd_rs),
        .cmd_rt    (cmd_rt),
        .cmd_rd    (cmd_rd),
        .cmd_imm   (cmd_imm),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_rd    (res_rd),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0: return (a - b + 16) % 16;
            1: return (a + b) % 16;
            2: return a | b;
            3: return a & b;
            4: return b / 2 + ((b >= 8) ? 8 : 0);
            5: return (a * 2) % 16 + a / 8;
            6: return 10 + ((a < b) ? 1 : 0);
            default: return 14 + ((a == b) ? 1 : 0);
        endcase
    endfunction

    // Called at a negedge; returns at a negedge after the result is consumed.
    task automatic do_cmd(input bit ld, input int op, input int rs, input int rt,
                          input int rd, input int imm, input int stall);
        int  exp_v, exp_lat, k, rd2;
        bit  seen;
        exp_v   = ld ? imm : ref_alu(op, model[rs], model[rt]);
        exp_lat = (ld && BYP) ? 1 : 3;
        model[rd] = exp_v;
        res_ready = (stall == 0);
        cmd_valid = 1'b1;
        cmd_ld    = ld;
        cmd_op    = 3'(op);
        cmd_rs    = RA_W'(rs);
        cmd_rt    = RA_W'(rt);
        cmd_rd    = RA_W'(rd);
        cmd_imm   = 4'(imm);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_idle: cmd_ready=%b want 1", cmd_ready);
        end
        @(posedge clk);
        accept_cycle = cyc;
        #1;
        cmd_valid = 1'b0;
        cmd_ld    = 1'($urandom);
        cmd_op    = 3'($urandom);
        cmd_rs    = RA_W'($urandom);
        cmd_rt    = RA_W'($urandom);
        cmd_rd    = RA_W'($urandom);
        cmd_imm   = 4'($urandom);
        seen = 0;
        k = 0;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (res_valid === 1'b1) seen = 1;
        end
        n_cmp++;
        if (!seen || k != exp_lat) begin
            n_fail++;
            $display("FAIL latency: res_valid after %0d cycles (seen=%0d) want %0d", k, seen, exp_lat);
        end
        n_cmp++;
        if (res_data !== 4'(exp_v) || res_rd !== RA_W'(rd)) begin
            n_fail++;
            $display("FAIL result: ld=%0d op=%0d rs=%0d rt=%0d got data=%h rd=%0d want data=%h rd=%0d",
                     ld, op, rs, rt, res_data, res_rd, exp_v, rd);
        end
        rd2 = (rd + 1) % NREG;
        for (int s = 0; s < stall; s++) begin
            cmd_valid = (s == 1);
            cmd_ld    = 1'b1;
            cmd_rd    = RA_W'(rd2);
            cmd_imm   = 4'(~model[rd2]);
            @(negedge clk);
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== 4'(exp_v) || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall: valid=%b data=%h ready=%b busy=%b want 1 %h 0 1",
                         res_valid, res_data, cmd_ready, busy, exp_v);
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL consume: valid=%b ready=%b busy=%b want 0 1 0", res_valid, cmd_ready, busy);
        end
        $display("cmd ld=%0d op=%0d rs=%0d rt=%0d rd=%0d imm=%0d -> data=%h lat=%0d", ld, op, rs, rt, rd, imm, res_data, k);
    endtask

    task automatic check_idle_outputs(input string tag);
        n_cmp++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 4'd0 || res_rd !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: ready=%b valid=%b data=%h rd=%0d busy=%b want 1 0 0 0 0",
                     tag, cmd_ready, res_valid, res_data, res_rd, busy);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREG; i++) model[i] = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_during");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_after");
        for (int i = 0; i < NREG; i++) do_cmd(0, 2, i, i, i, 0, 0);
    endtask

    task automatic test_directed();
        do_cmd(1, 0, 0, 0, 0, 7, 0);
        do_cmd(1, 0, 0, 0, 1, 3, 0);
        do_cmd(0, 1, 0, 1, 2, 0, 0);
        do_cmd(1, 0, 0, 0, 0, 3, 0);
        do_cmd(1, 0, 0, 0, 1, 7, 0);
        do_cmd(0, 0, 0, 1, 2, 0, 0);
        do_cmd(0, 6, 0, 1, 2, 0, 0);
        do_cmd(0, 7, 0, 1, 2, 0, 0);
        do_cmd(1, 0, 0, 0, 0, 5, 0);
        do_cmd(1, 0, 0, 0, 1, 5, 0);
        do_cmd(0, 7, 0, 1, 2, 0, 0);
        do_cmd(1, 0, 0, 0, 1, 9, 0);
        do_cmd(0, 4, 0, 1, 2, 0, 0);
        do_cmd(1, 0, 0, 0, 0, 9, 0);
        do_cmd(0, 5, 0, 1, 2, 0, 0);
        do_cmd(1, 0, 0, 0, 0, 15, 0);
        do_cmd(1, 0, 0, 0, 1, 15, 0);
        do_cmd(0, 1, 0, 1, 2, 0, 0);
        do_cmd(0, 1, 2, 2, 2, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            do_cmd(($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)), int'($urandom_range(0, NREG - 1)),
                   int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
                   int'($urandom_range(0, 15)), 0);
    endtask

    task automatic test_stall();
        do_cmd(1, 0, 0, 0, 1, 6, 0);
        do_cmd(0, 1, 1, 1, 0, 0, 5);
        do_cmd(0, 2, 1, 1, 3, 0, 0);
    endtask

    task automatic test_back_to_back();
        int prev;
        do_cmd(0, 1, 0, 1, 2, 0, 0);
        for (int n = 0; n < 4; n++) begin
            prev = accept_cycle;
            do_cmd(0, int'($urandom_range(0, 7)), 2, int'($urandom_range(0, NREG - 1)), 2, 0, 0);
            n_cmp++;
            if (accept_cycle - prev != 4) begin
                n_fail++;
                $display("FAIL throughput: accept spacing %0d want 4", accept_cycle - prev);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit saw_valid;
        do_cmd(1, 0, 0, 0, 3, 12, 0);
        cmd_valid = 1'b1;
        cmd_ld    = 1'b1;
        cmd_rd    = RA_W'(3);
        cmd_imm   = 4'd9;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b want 1", busy);
        end
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_async");
        saw_valid = 0;
        repeat (2) begin
            @(negedge clk);
            if (res_valid !== 1'b0) saw_valid = 1;
        end
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) saw_valid = 1;
        end
        n_cmp++;
        if (saw_valid) begin
            n_fail++;
            $display("FAIL dropped_cmd: res_valid=1 seen want 0");
        end
        check_idle_outputs("reset_mid_after");
        $display("reset mid-EXEC applied");
        do_cmd(0, 2, 3, 3, 3, 0, 0);
        do_cmd(0, 2, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter NREG, default 4, number of 4-bit registers in the internal register file; legal values are 2, 4 and 8.
REQ-002 Parameter RA_W, default $clog2(NREG), width of register-address fields.
REQ-003 Ports clk, input, 1, single clock; all flops are rising-edge.
REQ-004 Ports rst, input, 1, reset; asynchronous, active-high.
REQ-005 Port cmd_valid, input, 1, a command is present.
REQ-006 Port cmd_ready, output, 1, the sequencer accepts a command this cycle.
REQ-007 Port cmd_ld, input, 1, load-immediate command; cmd_op, cmd_rs and cmd_rt are ignored.
REQ-008 Port cmd_op, input, 3, ALU opcode.
REQ-009 Ports cmd_rs, cmd_rt and cmd_rd, input, RA_W each, source and destination register indices.
REQ-010 Port cmd_imm, input, 4, immediate value for cmd_ld.
REQ-011 Port res_valid, output, 1, a result is presented.
REQ-012 Port res_ready, input, 1, the consumer takes the result.
REQ-013 Port res_data, output, 4, result value.
REQ-014 Port res_rd, output, RA_W, destination index of the result.
REQ-015 Port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 The block SHALL be a four-state FSM: IDLE -> READ -> EXEC -> DONE -> IDLE.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid=1 and cmd_ready=1.
REQ-018 On acceptance, the op, ld, rd and imm fields SHALL be latched and the state SHALL go to READ.
REQ-019 In READ, the operand registers SHALL capture regfile[rs] and regfile[rt], and the state SHALL go to EXEC.
REQ-020 In EXEC, the result register SHALL capture the ALU output (cmd_imm if ld=1), regfile[rd] SHALL be written with that same value, and the state SHALL go to DONE.
REQ-021 res_valid SHALL be 1 only in DONE, with res_data and res_rd held stable until res_valid=1 and res_ready=1; then the state SHALL go to IDLE.
REQ-022 If a command is accepted in cycle N, res_valid SHALL first be 1 in cycle N+3; sustained throughput SHALL be one command per 4 cycles when res_ready=1.
REQ-023 The ALU SHALL be purely combinational, 4-bit, modulo 16, with no carry or flags.
REQ-024 Opcode 000 SHALL give rs-rt.
REQ-025 Opcode 001 SHALL give rs+rt.
REQ-026 Opcode 010 SHALL give rs|rt.
REQ-027 Opcode 011 SHALL give rs&rt.
REQ-028 Opcode 100 SHALL give {rt[3],rt[3:1]}, an arithmetic right shift of rt by 1.
REQ-029 Opcode 101 SHALL give {rs[2:0],rs[3]}, a rotate left of rs by 1.
REQ-030 Opcode 110 SHALL give {3'b101, rs<rt unsigned}.
REQ-031 Opcode 111 SHALL give {3'b111, rs==rt}.
REQ-032 A command whose rd equals its rs or rt SHALL read the pre-write value, because READ precedes EXEC.
REQ-033 A back-to-back command SHALL observe the previous write-back, because the write occurs before IDLE.
REQ-034 cmd_valid, cmd_ld, cmd_op, cmd_rs, cmd_rt, cmd_rd and cmd_imm SHALL be ignored outside IDLE.
REQ-035 The register file SHALL be updated even if the result is never consumed; a held res_ready=0 stalls only in DONE.

Reset
REQ-036 Asserting rst, including mid-operation, SHALL force state=IDLE and clear all regfile entries, operand registers and the result register to 0; an in-flight command is dropped with no write.
REQ-037 During and immediately after reset, outputs SHALL be cmd_ready=1, res_valid=0, res_data=0, res_rd=0 and busy=0.

Configuration
REQ-038 With ALU_SEQ_BYPASS_EN defined, an accepted cmd_ld SHALL skip READ and EXEC: the regfile write and result capture SHALL occur on the acceptance edge and res_valid SHALL be 1 in cycle N+1.
REQ-039 Without ALU_SEQ_BYPASS_EN, cmd_ld SHALL follow the full N+3 path; ALU opcodes are unaffected in both builds.

Structure
REQ-040 Package alu_seq_pkg SHALL hold the opcode enum (OP_SUB..OP_EQ), the FSM state enum, and constants LT_PREFIX=3'b101 and EQ_PREFIX=3'b111.
REQ-041 The ALU SHALL be one sub-module, alu4_core, with inputs rs, rt and op and output rd; the FSM, regfile and handshake SHALL stay in alu_sequencer.

Verification
REQ-042 Reset, then LD r0=7 and LD r1=3, then op=001 rs=r0 rt=r1 rd=r2 -> res_data=4'hA, res_rd=2, res_valid 3 cycles after acceptance.
REQ-043 With r0=3 and r1=7: op=000 -> 4'hC; op=110 -> 4'hB; op=111 -> 4'hE; with r0=r1=5, op=111 -> 4'hF.
REQ-044 With r1=4'h9, op=100 -> 4'hC; with r0=4'h9, op=101 -> 4'h3; with r0=r1=4'hF, op=001 -> 4'hE (wrap).
REQ-045 Hold res_ready=0 for 5 cycles in DONE -> res_data stable, cmd_ready=0, and a cmd_valid pulse during the stall is ignored (regfile unchanged).
REQ-046 Assert rst during EXEC of LD r3=9 -> r3 reads 0 afterward, res_valid never asserts, and cmd_ready=1 in the cycle after rst deasserts.
REQ-047 With ALU_SEQ_BYPASS_EN defined, LD r0=5 -> res_valid in cycle N+1; a following op=001 rs=r0 rt=r0 -> 4'hA.
